register_restore: RTL and testbench
===================================

Name: register_restore

Overview:
- Write-back side counterpart of the register snapshot block. On a branch misprediction it copies the saved register image back into the register file through a dedicated restore write port, one register per cycle.
- Sits between hazard control, the snapshot block and the register file.
- Asserts a stall (restore_busy) while restoring, and pulses restore_done when the register file again matches the snapshot.

Parameters:
- DRAIN_CYCLES, 1, cycles to wait after restore_req so in-flight WB commits before overwrite (1..3 legal).
- NUM_REGS, 32, architectural register count; r0 is never written.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- snap_regs  input  `DATA_WIDTH x 32  saved register image from snapshot block
- snapshot_done  input  1  one-cycle pulse: snapshot block latched a new image
- restore_req  input  1  misprediction: restore to last snapshot (from hazard control)
- wb_we  input  1  register file write enable from WB stage
- wb_addr  input  5  register file write address from WB stage
- restore_we  output  1  restore write enable to register file (has priority over WB)
- restore_addr  output  5  restore write address
- restore_data  output  `DATA_WIDTH  restore write data
- restore_busy  output  1  high in DRAIN/WRITE/DONE; hazard control stalls fetch/issue
- restore_done  output  1  one-cycle pulse: restore complete
- restore_err  output  1  one-cycle pulse: restore_req with no valid snapshot

Behaviour:
- Reset (async, rst_n low): state IDLE; snap_valid=0; dirty=0; all outputs 0; restore_addr=0.
- snap_valid: set by snapshot_done in IDLE; stays set after a completed restore, so the same image can be restored again; cleared only by reset.
- snapshot_done outside IDLE is ignored. Hazard control must not request a snapshot while restore_busy=1.
- States: IDLE, DRAIN, WRITE, DONE.
- IDLE:
  - restore_req && snap_valid -> DRAIN, counter=DRAIN_CYCLES-1.
  - restore_req && !snap_valid -> restore_err=1 next cycle; stay IDLE; no writes.
  - restore_req and snapshot_done in the same cycle: snapshot is accepted first, then the restore uses the new image, so it proceeds.
- DRAIN: counter decrements each cycle. At 0 -> WRITE with restore_addr=1 (feature off).
- WRITE:
  - restore_we=1, restore_data=snap_regs[restore_addr] (combinational select); restore_addr increments each cycle.
  - After addr 31 is written -> DONE. Exactly 31 writes; r0 never written.
- DONE: restore_done=1 for one cycle, restore_busy still 1; -> IDLE.
- Latency, feature off: restore_req sampled at edge 0; writes on cycles DRAIN_CYCLES+1 .. DRAIN_CYCLES+31; restore_done at cycle DRAIN_CYCLES+32.
- restore_req while not IDLE is ignored; no queueing.
- restore_busy=1 in DRAIN, WRITE and DONE.
- wb_we during WRITE/DONE is a protocol violation: pipeline is flushed. The register file gives restore_we priority.
- Reset mid-restore: immediate return to IDLE, all outputs 0, snap_valid=0. Partially restored register file is left as-is.

Optional Feature:
- Macro: RESTORE_DIRTY_ONLY_EN.
- Defined:
  - Maintain dirty[31:1]; dirty[wb_addr] set on wb_we && wb_addr!=0 in IDLE and DRAIN.
  - All dirty bits cleared when snapshot_done is accepted.
  - WRITE writes only dirty registers, lowest index first, one per cycle (priority encoder), clearing each bit as it is written.
  - DRAIN exits to DONE directly if no dirty bits remain; exits to WRITE otherwise.
  - Latency = DRAIN_CYCLES + popcount(dirty) + 1.
- Undefined: no dirty storage; all 31 registers are always written; wb_we/wb_addr unused.

Test Plan:
- Reset, then restore_req=1 with no snapshot -> restore_err pulse next cycle, restore_we never asserted, restore_busy stays 0.
- snapshot_done with snap_regs[i]=32'hA000_0000+i, then restore_req, DRAIN_CYCLES=1:
  - restore_we high cycles 2..32, addr 1..31, data 32'hA000_0001..32'hA000_001F;
  - restore_done at cycle 33; addr 0 never written.
- Second restore_req after completion, no new snapshot -> same 31 writes repeated (snap_valid retained).
- restore_req pulses and snapshot_done during WRITE -> ignored: exactly 31 writes, single restore_done, image unchanged.
- rst_n low at write of addr 10 -> outputs 0 asynchronously; later restore_req -> restore_err (snap_valid cleared).
- RESTORE_DIRTY_ONLY_EN: after snapshot, wb writes to r3, r7, r3, r0 -> writes r3 then r7 only; restore_done at cycle DRAIN_CYCLES+3. With no wb writes -> no writes; restore_done at cycle DRAIN_CYCLES+1.

Source files
------------

// File: rtl/register_restore.sv
`default_nettype none
// ============================================================================
// Module   : register_restore
// Purpose  : Copies the saved snapshot image back into the register file
//            after a misprediction, one register per cycle. Optional macro
//            RESTORE_DIRTY_ONLY_EN restricts writes to registers touched by WB.
// Revision : 1.0 - initial release
// ============================================================================
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module register_restore #(
    parameter int DRAIN_CYCLES = 1,
    parameter int NUM_REGS     = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [`DATA_WIDTH-1:0] snap_regs [NUM_REGS],
    input  logic                   snapshot_done,
    input  logic                   restore_req,
    input  logic                   wb_we,
    input  logic [4:0]             wb_addr,
    output logic                   restore_we,
    output logic [4:0]             restore_addr,
    output logic [`DATA_WIDTH-1:0] restore_data,
    output logic                   restore_busy,
    output logic                   restore_done,
    output logic                   restore_err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRAIN = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [1:0] c_DRAIN_INIT = 2'(DRAIN_CYCLES - 1);
    localparam logic [4:0] c_LAST_ADDR  = 5'(NUM_REGS - 1);

    state_t     r_state, w_state_nxt;
    logic [1:0] r_cnt, w_cnt_nxt;
    logic [4:0] r_addr, w_addr_nxt;
    logic       r_snap_valid, w_snap_valid_nxt;
    logic       r_err, w_err_nxt;

`ifdef RESTORE_DIRTY_ONLY_EN
    logic [NUM_REGS-1:0] r_dirty, w_dirty_nxt, w_dirty_eff, w_wb_set;
    logic [4:0]          w_low;

    // A WB write in the same cycle as an accepted snapshot post-dates the image.
    always_comb begin
        w_wb_set = '0;
        if (wb_we && (wb_addr != 5'd0) && ((r_state == S_IDLE) || (r_state == S_DRAIN)))
            w_wb_set[wb_addr] = 1'b1;
        w_dirty_eff = (((r_state == S_IDLE) && snapshot_done) ? '0 : r_dirty) | w_wb_set;
        w_low = 5'd0;
        for (int i = NUM_REGS - 1; i >= 1; i--) begin
            if (w_dirty_eff[i])
                w_low = 5'(i);
        end
    end
`else
    logic unused_wb;
    assign unused_wb = wb_we ^ (^wb_addr);
`endif

    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_addr_nxt       = r_addr;
        w_snap_valid_nxt = r_snap_valid;
        w_err_nxt        = 1'b0;
`ifdef RESTORE_DIRTY_ONLY_EN
        w_dirty_nxt      = w_dirty_eff;
`endif
        case (r_state)
            S_IDLE: begin
                if (snapshot_done)
                    w_snap_valid_nxt = 1'b1;
                if (restore_req) begin
                    if (r_snap_valid || snapshot_done) begin
                        w_state_nxt = S_DRAIN;
                        w_cnt_nxt   = c_DRAIN_INIT;
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                if (r_cnt != 2'd0) begin
                    w_cnt_nxt = r_cnt - 2'd1;
`ifdef RESTORE_DIRTY_ONLY_EN
                end else if (|w_dirty_eff) begin
                    w_state_nxt        = S_WRITE;
                    w_addr_nxt         = w_low;
                    w_dirty_nxt[w_low] = 1'b0;
                end else begin
                    w_state_nxt = S_DONE;
                end
`else
                end else begin
                    w_state_nxt = S_WRITE;
                    w_addr_nxt  = 5'd1;
                end
`endif
            end
            S_WRITE: begin
`ifdef RESTORE_DIRTY_ONLY_EN
                if (|w_dirty_eff) begin
                    w_addr_nxt         = w_low;
                    w_dirty_nxt[w_low] = 1'b0;
                end else begin
                    w_state_nxt = S_DONE;
                end
`else
                if (r_addr == c_LAST_ADDR)
                    w_state_nxt = S_DONE;
                else
                    w_addr_nxt = r_addr + 5'd1;
`endif
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
                w_addr_nxt  = 5'd0;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_cnt        <= 2'd0;
            r_addr       <= 5'd0;
            r_snap_valid <= 1'b0;
            r_err        <= 1'b0;
`ifdef RESTORE_DIRTY_ONLY_EN
            r_dirty      <= '0;
`endif
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_addr       <= w_addr_nxt;
            r_snap_valid <= w_snap_valid_nxt;
            r_err        <= w_err_nxt;
`ifdef RESTORE_DIRTY_ONLY_EN
            r_dirty      <= w_dirty_nxt;
`endif
        end
    end

    // Data is gated so the write port is fully quiet outside WRITE.
    assign restore_we   = (r_state == S_WRITE);
    assign restore_addr = r_addr;
    assign restore_data = restore_we ? snap_regs[r_addr] : '0;
    assign restore_busy = (r_state != S_IDLE);
    assign restore_done = (r_state == S_DONE);
    assign restore_err  = r_err;

endmodule

`default_nettype wire

// File: tb/tb_register_restore.sv
`default_nettype none
// ============================================================================
// Module   : tb_register_restore
// Purpose  : Directed self-checking bench for register_restore.
// Revision : 1.0 - initial release
// ============================================================================
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module tb_register_restore;

    localparam int DRAIN = 1;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [`DATA_WIDTH-1:0] snap_regs [32];
    logic                   snapshot_done;
    logic                   restore_req;
    logic                   wb_we;
    logic [4:0]             wb_addr;
    logic                   restore_we;
    logic [4:0]             restore_addr;
    logic [`DATA_WIDTH-1:0] restore_data;
    logic                   restore_busy;
    logic                   restore_done;
    logic                   restore_err;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_addr[$];

    register_restore #(.DRAIN_CYCLES(DRAIN), .NUM_REGS(32)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .snap_regs     (snap_regs),
        .snapshot_done (snapshot_done),
        .restore_req   (restore_req),
        .wb_we         (wb_we),
        .wb_addr       (wb_addr),
        .restore_we    (restore_we),
        .restore_addr  (restore_addr),
        .restore_data  (restore_data),
        .restore_busy  (restore_busy),
        .restore_done  (restore_done),
        .restore_err   (restore_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic take_snapshot();
        @(negedge clk) snapshot_done = 1'b1;
        @(negedge clk) snapshot_done = 1'b0;
    endtask

    task automatic wb_write(input logic [4:0] a);
        @(negedge clk) begin wb_we = 1'b1; wb_addr = a; end
        @(negedge clk) wb_we = 1'b0;
    endtask

    task automatic run_err(input string tag);
        @(negedge clk) restore_req = 1'b1;
        @(negedge clk) restore_req = 1'b0;
        check({tag, " err"}, 64'(restore_err), 64'd1);
        check({tag, " busy"}, 64'(restore_busy), 64'd0);
        check({tag, " we"}, 64'(restore_we), 64'd0);
        @(negedge clk);
        check({tag, " err_pulse"}, 64'(restore_err), 64'd0);
        check({tag, " busy2"}, 64'(restore_busy), 64'd0);
    endtask

    // Cycle k is the interval following edge k-1; restore_req is sampled at edge 0.
    task automatic run_restore(input string tag, input bit inject);
        int nw, ndone, done_cyc, nbusy;
        nw = 0; ndone = 0; done_cyc = -1; nbusy = 0;
        @(negedge clk) restore_req = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 45; k++) begin
            @(negedge clk);
            restore_req   = 1'b0;
            snapshot_done = 1'b0;
            if (restore_we) begin
                if (nw < exp_addr.size()) begin
                    check({tag, " addr"}, 64'(restore_addr), 64'(exp_addr[nw]));
                    check({tag, " data"}, 64'(restore_data), 64'(32'hA000_0000 + exp_addr[nw]));
                    check({tag, " wcyc"}, 64'(k), 64'(DRAIN + 1 + nw));
                end
                nw++;
            end
            if (restore_busy) nbusy++;
            if (restore_done) begin
                ndone++;
                if (done_cyc < 0) done_cyc = k;
            end
            if (inject && (k == 10 || k == 20)) begin
                restore_req   = 1'b1;
                snapshot_done = 1'b1;
            end
        end
        check({tag, " nwrites"}, 64'(nw), 64'(exp_addr.size()));
        check({tag, " ndone"}, 64'(ndone), 64'd1);
        check({tag, " done_cyc"}, 64'(done_cyc), 64'(DRAIN + exp_addr.size() + 1));
        check({tag, " nbusy"}, 64'(nbusy), 64'(DRAIN + exp_addr.size() + 1));
    endtask

    initial begin
        bit hit;
        for (int i = 0; i < 32; i++) snap_regs[i] = 32'hA000_0000 + 32'(i);
        snapshot_done = 1'b0; restore_req = 1'b0; wb_we = 1'b0; wb_addr = 5'd0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst we", 64'(restore_we), 64'd0);
        check("rst addr", 64'(restore_addr), 64'd0);
        check("rst data", 64'(restore_data), 64'd0);
        check("rst busy", 64'(restore_busy), 64'd0);
        check("rst done", 64'(restore_done), 64'd0);
        check("rst err", 64'(restore_err), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_err("nosnap");
        take_snapshot();

`ifdef RESTORE_DIRTY_ONLY_EN
        wb_write(5'd3); wb_write(5'd7); wb_write(5'd3); wb_write(5'd0);
        exp_addr = '{3, 7};
        run_restore("dirty", 1'b0);
        exp_addr = '{};
        run_restore("again", 1'b0);
        take_snapshot();
        run_restore("clean", 1'b0);
        take_snapshot();
        wb_write(5'd10);
`else
        exp_addr = '{};
        for (int i = 1; i < 32; i++) exp_addr.push_back(i);
        run_restore("full", 1'b0);
        run_restore("again", 1'b0);
        run_restore("inject", 1'b1);
`endif

        // Asynchronous reset in the middle of the restore, at the write of r10.
        @(negedge clk) restore_req = 1'b1;
        @(negedge clk) restore_req = 1'b0;
        hit = 1'b0;
        for (int k = 0; k < 40 && !hit; k++) begin
            if (restore_we && restore_addr == 5'd10) hit = 1'b1;
            else @(negedge clk);
        end
        check("mid reach r10", 64'(hit), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("mid we", 64'(restore_we), 64'd0);
        check("mid addr", 64'(restore_addr), 64'd0);
        check("mid data", 64'(restore_data), 64'd0);
        check("mid busy", 64'(restore_busy), 64'd0);
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        run_err("afterrst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
